cpu1_div_cell: RTL and testbench

//  Iterative radix-2 restoring divider for the cpu1 A-stage, the inverse of the

---
 rtl/cpu1_div_cell.sv | 128 ++++++++++++
 tb/tb_cpu1_div_cell.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu1_div_cell.sv
// cpu1_div_cell: iterative radix-2 restoring divider for the cpu1 A-stage.
// It serves signed and unsigned divide and remainder operations, producing
// one quotient bit per clock behind a start/busy/done handshake.
//
// Ports:
//   clk               - rising-edge clock
//   reset             - synchronous active-high reset
//   A_div_src1        - dividend
//   A_div_src2        - divisor
//   A_div_start       - request, accepted only in IDLE and not during done
//   A_div_signed      - 1 = two's-complement operands, 0 = unsigned
//   A_div_rem         - 1 = return remainder, 0 = return quotient
//   A_div_busy        - high from the cycle after accept until done
//   A_div_done        - one-cycle pulse, result valid
//   A_div_cell_result - quotient or remainder, held until the next accept
module cpu1_div_cell #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic             A_div_rem,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_cell_result
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIXUP} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_raw;    // dividend as latched, needed for divide-by-zero
  logic [WIDTH-1:0] dvs;        // divisor, raw until PREP, then magnitude
  logic [WIDTH-1:0] rem_acc;    // partial remainder
  logic [WIDTH-1:0] quo_acc;    // dividend magnitude shifting out, quotient shifting in
  logic             sgn_op;
  logic             sel_rem;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
  // The remainder stays below the divisor, so WIDTH+1 bits hold the sign.
  assign shifted = {rem_acc, quo_acc[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  // Sign correction and divide-by-zero override for the final result.
  always_comb begin
    q_fix = neg_q ? (WIDTH'(0) - quo_acc) : quo_acc;
    r_fix = neg_r ? (WIDTH'(0) - rem_acc) : rem_acc;
    if (dvs == '0) begin
      q_fix = {WIDTH{1'b1}};
      r_fix = dvd_raw;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      A_div_busy        <= 1'b0;
      A_div_done        <= 1'b0;
      A_div_cell_result <= '0;
      dvd_raw           <= '0;
      dvs               <= '0;
      rem_acc           <= '0;
      quo_acc           <= '0;
      sgn_op            <= 1'b0;
      sel_rem           <= 1'b0;
      neg_q             <= 1'b0;
      neg_r             <= 1'b0;
      cnt               <= '0;
    end else begin
      A_div_done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (A_div_start && !A_div_done) begin
            dvd_raw    <= A_div_src1;
            dvs        <= A_div_src2;
            sgn_op     <= A_div_signed;
            sel_rem    <= A_div_rem;
            A_div_busy <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          // Magnitudes; 0x80..0 negates to its own bit pattern, read unsigned.
          quo_acc <= (sgn_op && dvd_raw[WIDTH-1]) ? (WIDTH'(0) - dvd_raw) : dvd_raw;
          dvs     <= (sgn_op && dvs[WIDTH-1])     ? (WIDTH'(0) - dvs)     : dvs;
          neg_q   <= sgn_op && (dvd_raw[WIDTH-1] ^ dvs[WIDTH-1]);
          neg_r   <= sgn_op && dvd_raw[WIDTH-1];
          rem_acc <= '0;
          cnt     <= CNT_W'(WIDTH);
          state   <= ITER;
        end
        ITER: begin
          if (trial[WIDTH]) begin
            rem_acc <= shifted[WIDTH-1:0];
          end else begin
            rem_acc <= trial[WIDTH-1:0];
          end
          quo_acc <= {quo_acc[WIDTH-2:0], ~trial[WIDTH]};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          A_div_cell_result <= sel_rem ? r_fix : q_fix;
          A_div_done        <= 1'b1;
          A_div_busy        <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu1_div_cell.sv
// tb_cpu1_div_cell: directed self-checking bench for cpu1_div_cell.
// Expected results are hand-computed constants.
module tb_cpu1_div_cell;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 34;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             start;
  logic             sgn;
  logic             rem;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  cpu1_div_cell #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .A_div_src1        (src1),
    .A_div_src2        (src2),
    .A_div_start       (start),
    .A_div_signed      (sgn),
    .A_div_rem         (rem),
    .A_div_busy        (busy),
    .A_div_done        (done),
    .A_div_cell_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns after the accepting edge.
  task automatic start_op(input logic [31:0] s1, input logic [31:0] s2,
                          input logic sg, input logic rm, input string tag);
    @(negedge clk);
    src1  = s1;
    src2  = s2;
    sgn   = sg;
    rem   = rm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs to prove operands were latched.
    src1 = $urandom;
    src2 = $urandom;
    sgn  = ~sg;
    rem  = ~rm;
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
  endtask

  // Watch a 60-cycle window after accept. junk_at > 0 drives a one-cycle
  // start with other operands after that many edges, which must be ignored.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int junk_at);
    int lat    = 0;
    int pulses = 0;
    logic [31:0] res = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          res = result;
          check({tag, "_busy_with_done"}, {31'd0, busy}, 32'd0);
        end
      end
      if (junk_at > 0 && n == junk_at) begin
        src1  = 32'd1000;
        src2  = 32'd3;
        sgn   = 1'b0;
        rem   = 1'b0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_result"}, res, exp);
    check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_result_held"}, result, exp);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [31:0] s1, input logic [31:0] s2,
                     input logic sg, input logic rm, input logic [31:0] exp,
                     input string tag);
    start_op(s1, s2, sg, rm, tag);
    wait_done(tag, exp, 0);
  endtask

  initial begin
    int stray;
    reset = 1'b1;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    sgn   = 1'b0;
    rem   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // T1 unsigned
    run(32'd100, 32'd7, 1'b0, 1'b0, 32'h0000000E, "t1_udiv");
    run(32'd100, 32'd7, 1'b0, 1'b1, 32'h00000002, "t1_urem");
    // T2 signed
    run(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD, "t2_sdiv");
    run(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, "t2_srem");
    run(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, "t2_srem_negdivisor");
    run(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, "t2_sdiv_negdivisor");
    // T3 divide by zero
    run(32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, "t3_udiv0");
    run(32'h12345678, 32'd0, 1'b0, 1'b1, 32'h12345678, "t3_urem0");
    run(32'h12345678, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, "t3_sdiv0");
    run(32'h12345678, 32'd0, 1'b1, 1'b1, 32'h12345678, "t3_srem0");
    run(32'h87654321, 32'd0, 1'b1, 1'b1, 32'h87654321, "t3_srem0_neg");
    // T4 overflow and extremes
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, "t4_ovf_div");
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, "t4_ovf_rem");
    run(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF, "t4_umax");
    run(32'h80000000, 32'd3, 1'b1, 1'b1, 32'hFFFFFFFE, "t4_minint_rem");

    // T5 start while busy, and start during the done cycle, are ignored
    start_op(32'd50, 32'd5, 1'b0, 1'b0, "t5_busy");
    wait_done("t5_busy", 32'd10, 10);
    start_op(32'd50, 32'd6, 1'b0, 1'b1, "t5_done");
    wait_done("t5_done", 32'd2, 34);

    // T6 reset mid-operation discards the op
    start_op(32'd100, 32'd7, 1'b0, 1'b0, "t6");
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_reset_busy", {31'd0, busy}, 32'd0);
    check("t6_reset_done", {31'd0, done}, 32'd0);
    check("t6_reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    check("t6_no_stray_done", 32'(stray), 32'd0);
    run(32'd1000, 32'd9, 1'b0, 1'b0, 32'd111, "t6_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
